// File: rtl/sram_slot_pkg.sv
// Shared definitions for the time-multiplexed SRAM slot requesters:
// slot-phase constants, bus widths, bridge state encoding and port records.
package sram_slot_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  // Slot phases as seen by the SRAM controller.
  localparam logic [1:0] PH_M1_ACC = 2'd0;  // M1 access
  localparam logic [1:0] PH_M1_RD  = 2'd1;  // M1 read
  localparam logic [1:0] PH_M2_ACC = 2'd2;  // M2 access: controller samples wr2_n, a2
  localparam logic [1:0] PH_M2_RW  = 2'd3;  // M2 read/write strobe, doutput2 loaded

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_SLOT_A,
    ST_SLOT_B,
    ST_RDCAP,
    ST_ACK
  } bridge_state_e;

  // Request captured at acceptance.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cpu_req_t;

  // Registered drive towards controller port 2.
  typedef struct packed {
    logic [ADDR_W-1:0] a2;
    logic [DATA_W-1:0] din2;
    logic              rd2_n;
    logic              wr2_n;
  } port2_t;

  localparam port2_t PORT2_IDLE = '{a2: '0, din2: '0, rd2_n: 1'b1, wr2_n: 1'b1};

endpackage

// File: rtl/sram_cpu_bridge_if.sv
// CPU-side request/acknowledge bus of the SRAM port-2 bridge.
interface sram_cpu_bridge_if;
  import sram_slot_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input busy, ack, rdata);
  modport slave  (input req, we, addr, wdata, output busy, ack, rdata);

endinterface

// File: rtl/slot_phase_counter.sv
// Free-running 2-bit slot-phase counter that tracks the SRAM controller's
// four-phase schedule. Shared by the port requesters.
module slot_phase_counter #(
  parameter logic [1:0] PHASE_INIT = 2'd0
) (
  input  logic       clk,
  output logic [1:0] phase,
  output logic       pre_slot
);
  import sram_slot_pkg::*;

  // NOTE: deliberately no reset; only the power-up value is set, so a bridge
  // reset can never knock the count out of step with the controller.
  logic [1:0] phase_q = PHASE_INIT;

  // Advance one phase per clock, wrapping 3 -> 0.
  always_ff @(posedge clk) begin
    phase_q <= phase_q + 2'd1;
  end

  assign phase    = phase_q;
  assign pre_slot = (phase_q == PH_M1_RD);

endmodule

// File: rtl/sram_cpu_bridge.sv
// CPU requester for port 2 of the time-multiplexed SRAM controller. Holds a
// single byte request until the next port-2 slot, drives the port with the
// phase alignment the controller samples, and acknowledges with one pulse.
module sram_cpu_bridge
  import sram_slot_pkg::*;
#(
  parameter logic [1:0] PHASE_INIT = PH_M1_ACC
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_cpu_bridge_if.slave       cpu,
  output logic [ADDR_W-1:0]      a2,
  output logic [DATA_W-1:0]      din2,
  output logic                   rd2_n,
  output logic                   wr2_n,
  input  logic [DATA_W-1:0]      dout2
);

  logic [1:0]        phase;
  logic              pre_slot;
  bridge_state_e     state_q, state_d;
  cpu_req_t          req_q, req_d;
  port2_t            p2_q, p2_d;
  logic [DATA_W-1:0] rdata_q;

  slot_phase_counter #(.PHASE_INIT(PHASE_INIT)) u_phase (
    .clk      (clk),
    .phase    (phase),
    .pre_slot (pre_slot)
  );

  // Next state and request latch: wait for the phase-1 cycle, then walk the slot.
  always_comb begin
    // NOTE: defaults first so every path assigns state_d and req_d; no latches.
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu.req) begin
          req_d   = '{we: cpu.we, addr: cpu.addr, wdata: cpu.wdata};
          state_d = (phase == PH_M1_RD) ? ST_SLOT_A : ST_PEND;
        end
      end
      ST_PEND:   if (pre_slot) state_d = ST_SLOT_A;
      ST_SLOT_A: state_d = ST_SLOT_B;
      ST_SLOT_B: state_d = req_q.we ? ST_ACK : ST_RDCAP;
      ST_RDCAP:  state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Port-2 drive for the state being entered, so it is registered for the whole state.
  always_comb begin
    p2_d = PORT2_IDLE;
    case (state_d)
      ST_SLOT_A, ST_SLOT_B: begin
        p2_d.a2 = req_d.addr;
        if (req_d.we) begin
          p2_d.din2  = req_d.wdata;
          p2_d.wr2_n = 1'b0;
        end else begin
          p2_d.rd2_n = 1'b0;
        end
      end
      ST_RDCAP: begin
        p2_d.a2    = req_d.addr;
        p2_d.rd2_n = 1'b0;
      end
      default: ;
    endcase
  end

  // State, request, port-2 and read-data registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state.
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      p2_q    <= PORT2_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      p2_q    <= p2_d;
      if (state_q == ST_RDCAP) rdata_q <= dout2;
    end
  end

  assign a2        = p2_q.a2;
  assign din2      = p2_q.din2;
  assign rd2_n     = p2_q.rd2_n;
  assign wr2_n     = p2_q.wr2_n;
  assign cpu.busy  = (state_q != ST_IDLE);
  assign cpu.ack   = (state_q == ST_ACK);
  assign cpu.rdata = rdata_q;

endmodule

// File: tb/tb_sram_cpu_bridge.sv
// Bench for sram_cpu_bridge: controller port-2 behaviour modelled from the
// slot schedule, latency expectations from the phase arithmetic.
module tb_sram_cpu_bridge;
  import sram_slot_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #25 clk = ~clk;

  sram_cpu_bridge_if cpu ();
  logic [ADDR_W-1:0] a2;
  logic [DATA_W-1:0] din2, dout2;
  logic              rd2_n, wr2_n;

  sram_cpu_bridge #(.PHASE_INIT(2'd0)) dut (
    .clk   (clk),
    .rst   (rst),
    .cpu   (cpu),
    .a2    (a2),
    .din2  (din2),
    .rd2_n (rd2_n),
    .wr2_n (wr2_n),
    .dout2 (dout2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Controller-side model: its own slot phase, SRAM array, activity counters.
  logic [1:0]        ctl_phase = 2'd0;
  logic [7:0]        sram [0:(1<<19)-1];
  logic              ctl_wr_pend = 1'b0;
  logic [18:0]       ctl_addr = '0;
  logic [7:0]        ctl_dout = 8'h00;
  int                wr_cnt = 0, rd_cnt = 0, ack_cnt = 0, both_low = 0, rd_low = 0;

  always @(posedge clk) ctl_phase <= ctl_phase + 2'd1;

  always @(negedge clk) begin
    if (ctl_phase == 2'd2) begin
      ctl_wr_pend <= !wr2_n;
      ctl_addr    <= a2;
    end
    if (ctl_phase == 2'd3) begin
      if (ctl_wr_pend && !wr2_n) begin
        sram[ctl_addr] <= din2;
        wr_cnt <= wr_cnt + 1;
      end
      if (!rd2_n) begin
        ctl_dout <= sram[ctl_addr];
        rd_cnt <= rd_cnt + 1;
      end
    end
    if (!rd2_n && !wr2_n) both_low <= both_low + 1;
    if (!rd2_n) rd_low <= rd_low + 1;
    if (cpu.ack) ack_cnt <= ack_cnt + 1;
  end

  assign dout2 = rd2_n ? 8'hEE : ctl_dout;

  logic [7:0] ref_mem [logic [18:0]];

  typedef struct {
    logic        we;
    logic [18:0] addr;
    logic [7:0]  wdata;
    int          p;
    int          exp_lat;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_latency(input logic we, input int p);
    return (we ? 3 : 4) + ((5 - p) % 4);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (cpu.busy && n < 30) begin
      tick();
      n++;
    end
    if (cpu.busy) check("idle_timeout", 32'(cpu.busy), 32'd0);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (int'(ctl_phase) != p && n < 4) begin
      tick();
      n++;
    end
  endtask

  // One request; p < 0 means accept in whatever phase comes up.
  task automatic do_op(input logic w, input logic [18:0] a, input logic [7:0] d, input int p,
                       output int lat, output logic [7:0] rd, output int ack_ph, output int p_acc);
    wait_idle();
    if (p >= 0) wait_phase(p);
    p_acc     = int'(ctl_phase);
    cpu.req   = 1'b1;
    cpu.we    = w;
    cpu.addr  = a;
    cpu.wdata = d;
    tick();
    cpu.req = 1'b0;
    lat = 1;
    while (!cpu.ack && lat < 20) begin
      tick();
      lat++;
    end
    rd     = cpu.rdata;
    ack_ph = int'(ctl_phase);
    if (w) ref_mem[a] = d;
    tick();
  endtask

  initial begin
    int lat, ack_ph, p_acc, snap, ack0, wr0, rd0;
    logic [7:0] rd;
    logic [18:0] pool [8];
    logic [1:0] b2b_we;
    logic [18:0] b2b_addr [3];
    logic [7:0] b2b_data [3];

    vecs[0] = '{1'b1, 19'h00010, 8'h11, 0, 4, 8'h00};
    vecs[1] = '{1'b0, 19'h00010, 8'h00, 0, 5, 8'h11};
    vecs[2] = '{1'b1, 19'h00020, 8'h22, 1, 3, 8'h00};
    vecs[3] = '{1'b0, 19'h00020, 8'h00, 1, 4, 8'h22};
    vecs[4] = '{1'b1, 19'h7FFFF, 8'h33, 2, 6, 8'h00};
    vecs[5] = '{1'b0, 19'h7FFFF, 8'h00, 2, 7, 8'h33};
    vecs[6] = '{1'b1, 19'h00000, 8'h44, 3, 5, 8'h00};
    vecs[7] = '{1'b0, 19'h00000, 8'h00, 3, 6, 8'h44};

    rst = 1'b1;
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.addr = '0; cpu.wdata = '0;
    repeat (3) tick();
    check("rst_busy",  32'(cpu.busy),  32'd0);
    check("rst_ack",   32'(cpu.ack),   32'd0);
    check("rst_rdata", 32'(cpu.rdata), 32'h00);
    check("rst_a2",    32'(a2),        32'h0);
    check("rst_din2",  32'(din2),      32'h0);
    check("rst_rd2_n", 32'(rd2_n),     32'd1);
    check("rst_wr2_n", 32'(wr2_n),     32'd1);
    rst = 1'b0;
    tick();

    // Directed write accepted at phase 1, watched cycle by cycle.
    wait_phase(1);
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = 19'h1A2B3; cpu.wdata = 8'h5C;
    tick();
    cpu.req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("w1_wr2_n_c%0d", c), 32'(wr2_n), 32'd0);
      check($sformatf("w1_rd2_n_c%0d", c), 32'(rd2_n), 32'd1);
      check($sformatf("w1_a2_c%0d", c),    32'(a2),    32'h1A2B3);
      check($sformatf("w1_din2_c%0d", c),  32'(din2),  32'h5C);
      check($sformatf("w1_ack_c%0d", c),   32'(cpu.ack), 32'd0);
      tick();
    end
    check("w1_ack",   32'(cpu.ack), 32'd1);
    check("w1_wr2_n", 32'(wr2_n),   32'd1);
    ref_mem[19'h1A2B3] = 8'h5C;
    tick();
    check("w1_sram", 32'(sram[19'h1A2B3]), 32'h5C);

    // Read at phase 2 of a location holding 0xA7.
    do_op(1'b1, 19'h0ABCD, 8'hA7, -1, lat, rd, ack_ph, p_acc);
    snap = rd_low;
    do_op(1'b0, 19'h0ABCD, 8'h00, 2, lat, rd, ack_ph, p_acc);
    check("r2_lat",    32'(lat),          32'd7);
    check("r2_rdata",  32'(rd),           32'hA7);
    check("r2_ackph",  32'(ack_ph),       32'd1);
    check("r2_rdlow",  32'(rd_low - snap), 32'd3);

    // Table sweep over acceptance phases, both directions.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].p, lat, rd, ack_ph, p_acc);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].we) begin
        check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
        check($sformatf("vec%0d_ackph", i), 32'(ack_ph), 32'd1);
      end
    end

    // Back-to-back: req held high, W/R/W.
    b2b_we = 2'b01;
    b2b_addr[0] = 19'h03000; b2b_data[0] = 8'hC3;
    b2b_addr[1] = 19'h03000; b2b_data[1] = 8'h00;
    b2b_addr[2] = 19'h03001; b2b_data[2] = 8'h3C;
    wait_idle();
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = b2b_addr[0]; cpu.wdata = b2b_data[0];
    for (int i = 0; i < 3; i++) begin
      logic op_we;
      op_we = (i != 1);
      p_acc = int'(ctl_phase);
      tick();
      check($sformatf("b2b%0d_accept", i), 32'(cpu.busy), 32'd1);
      lat = 1;
      while (!cpu.ack && lat < 20) begin
        tick();
        lat++;
      end
      check($sformatf("b2b%0d_lat", i), 32'(lat), 32'(exp_latency(op_we, p_acc)));
      if (op_we) ref_mem[b2b_addr[i]] = b2b_data[i];
      else check("b2b_rdata", 32'(cpu.rdata), 32'hC3);
      if (i < 2) begin
        cpu.we = (i + 1 != 1); cpu.addr = b2b_addr[i+1]; cpu.wdata = b2b_data[i+1];
      end else begin
        cpu.req = 1'b0;
      end
      tick();
      check($sformatf("b2b%0d_idle", i), 32'(cpu.busy), 32'd0);
    end
    check("b2b_sram", 32'(sram[19'h03001]), 32'h3C);

    // Requests pulsed while busy are ignored.
    tick();
    ack0 = ack_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = 19'h00100; cpu.wdata = 8'h6D;
    tick();
    for (int k = 0; k < 20; k++) begin
      if (cpu.ack) break;
      cpu.req = k[0]; cpu.we = 1'b1; cpu.addr = 19'h00200; cpu.wdata = 8'h99;
      tick();
    end
    cpu.req = 1'b0;
    ref_mem[19'h00100] = 8'h6D;
    repeat (3) tick();
    check("busy_acks",   32'(ack_cnt - ack0), 32'd1);
    check("busy_writes", 32'(wr_cnt - wr0),   32'd1);
    check("busy_reads",  32'(rd_cnt - rd0),   32'd0);
    check("busy_sram",   32'(sram[19'h00100]), 32'h6D);
    check("busy_idle",   32'(cpu.busy), 32'd0);

    // Reset while in SLOT_A of a write of 0xFF over 0x00.
    do_op(1'b1, 19'h05555, 8'h00, -1, lat, rd, ack_ph, p_acc);
    tick();
    ack0 = ack_cnt; wr0 = wr_cnt;
    wait_phase(1);
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = 19'h05555; cpu.wdata = 8'hFF;
    tick();
    cpu.req = 1'b0;
    check("rsta_slot_wr2_n", 32'(wr2_n), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rsta_busy",  32'(cpu.busy),  32'd0);
    check("rsta_ack",   32'(cpu.ack),   32'd0);
    check("rsta_rdata", 32'(cpu.rdata), 32'h00);
    check("rsta_a2",    32'(a2),        32'h0);
    check("rsta_din2",  32'(din2),      32'h0);
    check("rsta_rd2_n", 32'(rd2_n),     32'd1);
    check("rsta_wr2_n", 32'(wr2_n),     32'd1);
    repeat (8) tick();
    check("rsta_no_ack",   32'(ack_cnt - ack0), 32'd0);
    check("rsta_no_write", 32'(wr_cnt - wr0),   32'd0);
    check("rsta_sram",     32'(sram[19'h05555]), 32'h00);
    do_op(1'b0, 19'h05555, 8'h00, -1, lat, rd, ack_ph, p_acc);
    check("rsta_after_lat",   32'(lat), 32'(exp_latency(1'b0, p_acc)));
    check("rsta_after_rdata", 32'(rd),  32'h00);

    // Reset together with req: request dropped.
    wait_idle();
    rst = 1'b1;
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = 19'h05555; cpu.wdata = 8'hEE;
    tick();
    rst = 1'b0;
    cpu.req = 1'b0;
    check("rstreq_busy0", 32'(cpu.busy), 32'd0);
    tick();
    check("rstreq_busy1", 32'(cpu.busy), 32'd0);

    // Randomised traffic over a pre-written address pool.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 19'($urandom_range(0, (1 << 19) - 1));
      do_op(1'b1, pool[i], 8'($urandom), -1, lat, rd, ack_ph, p_acc);
      check($sformatf("pool%0d_lat", i), 32'(lat), 32'(exp_latency(1'b1, p_acc)));
    end
    for (int i = 0; i < 40; i++) begin
      logic w;
      logic [18:0] a;
      logic [7:0] d, exp_rd;
      int p;
      w = 1'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 7)];
      d = 8'($urandom);
      p = $urandom_range(0, 3);
      exp_rd = ref_mem[a];
      repeat ($urandom_range(0, 2)) tick();
      do_op(w, a, d, p, lat, rd, ack_ph, p_acc);
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_latency(w, p_acc)));
      if (!w) check($sformatf("rnd%0d_rdata", i), 32'(rd), 32'(exp_rd));
    end

    tick();
    check("never_both_low", 32'(both_low), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_cpu_bridge.md
# sram_cpu_bridge

CPU-side requester for port 2 of the time-multiplexed SRAM controller. It accepts single-byte read or write requests over a req/ack handshake and holds the request until the next port-2 slot. During that slot it drives `a2`/`din2`/`rd2_n`/`wr2_n` with the exact phase alignment the controller samples, then captures `dout2` and returns it with a one-cycle `ack`. It sits between the CPU bus decoder and the SRAM controller, which has no wait or ack signalling of its own.

## Interface
Parameters:
- `PHASE_INIT`, 0 — power-up value of the internal slot-phase counter; must equal the controller's power-up slot (0 = M1 access).

Ports:
- `clk` in 1 — 20 MHz system clock, same clock as the SRAM controller.
- `rst` in 1 — synchronous, active-high reset.
- `req` in 1 — request strobe; sampled only while `busy`=0.
- `we` in 1 — 1 = write, 0 = read; sampled with `req`.
- `addr` in 19 — byte address; sampled with `req`.
- `wdata` in 8 — write data; sampled with `req`.
- `busy` out 1 — high from the cycle after acceptance through the ack cycle.
- `ack` out 1 — one-cycle completion pulse.
- `rdata` out 8 — read data; valid when `ack`=1 for a read; holds until the next read completes.
- `a2` out 19 — SRAM address to controller port 2.
- `din2` out 8 — write data to controller port 2.
- `rd2_n` out 1 — active-low read select; enables the controller's `dout2` driver.
- `wr2_n` out 1 — active-low write request.
- `dout2` in 8 — read data from the controller; valid only while `rd2_n`=0.

## Operation
- Slot phase counter (2 bits) increments every cycle, wrapping 3→0. It is initialised to `PHASE_INIT` at configuration and is not affected by `rst`, which keeps it aligned with the controller.
- Phase meaning: 0 = M1 access, 1 = M1 read, 2 = M2 access (controller samples `wr2_n` and `a2`), 3 = M2 read/write (write strobe; `doutput2` loaded at the end of the cycle).
- FSM states: IDLE, PEND, SLOT_A, SLOT_B, RDCAP, ACK.
- IDLE with `req`=1:
  - latch `we`, `addr` and `wdata`;
  - go to SLOT_A if the current phase is 1, otherwise go to PEND.
- PEND → SLOT_A on the edge where the phase goes 1→2.
- SLOT_A (phase 2) → SLOT_B (phase 3).
- SLOT_B → ACK for a write, or → RDCAP for a read (phase 0).
- RDCAP → ACK (phase 1). `rdata` ← `dout2` on the edge ending RDCAP.
- ACK → IDLE unconditionally.
- Port-2 outputs are registered and valid for the whole state:
  - SLOT_A and SLOT_B: `a2`=latched address.
  - Write: `wr2_n`=0 and `din2`=latched data in SLOT_A and SLOT_B; `rd2_n`=1.
  - Read: `rd2_n`=0 in SLOT_A, SLOT_B and RDCAP; `a2` is also held in RDCAP; `wr2_n`=1.
  - All other states: `a2`=0, `din2`=0, `rd2_n`=1, `wr2_n`=1.
- `busy` = (state ≠ IDLE). `ack` = (state = ACK).
- `req` is ignored while busy; there is no queue. A request held high through ACK is re-accepted in the first IDLE cycle.

## Timing
- Reset values: state IDLE, `busy`=0, `ack`=0, `rdata`=0x00, `a2`=0, `din2`=0, `rd2_n`=1, `wr2_n`=1.
- Let p be the phase in the acceptance cycle. Write ack arrives 3 + ((1−p) mod 4) cycles after acceptance:
  - p=1 → 3 cycles
  - p=0 → 4 cycles
  - p=3 → 5 cycles
  - p=2 → 6 cycles
- Read ack arrives one cycle later than a write (4..7 cycles); the ack always lands in phase 1.
- Minimum spacing between accepted requests: ack cycle + 1 (the next accept is in the IDLE cycle after ACK).
- `rst` asserted while in SLOT_A:
  - outputs are idle in the phase-3 cycle;
  - the controller re-checks `wr2_n` in phase 3, so no SRAM write occurs;
  - no `ack` is generated.
- `rst` asserted in SLOT_B: the write completes in SRAM, but no `ack` is generated.
- `rst` asserted in RDCAP: `rdata` is reset to 0x00 and not updated.
- `rst` together with `req`: reset wins and the request is dropped.

## Structure
- Shared package `sram_slot_pkg`:
  - phase constants `PH_M1_ACC`=0, `PH_M1_RD`=1, `PH_M2_ACC`=2, `PH_M2_RW`=3;
  - bridge state encoding;
  - address width 19 and data width 8.
- Sub-module `slot_phase_counter`:
  - free-running 2-bit counter with `PHASE_INIT`;
  - outputs `phase` and `pre_slot` (phase = 1);
  - to be reused by the video fetch requester on port 1.

## Test plan
- Write at p=1: `addr`=0x1A2B3, `wdata`=0x5C → `wr2_n`=0 with `a2`=0x1A2B3 and `din2`=0x5C exactly in phases 2–3; `ack` 3 cycles after acceptance; SRAM model byte = 0x5C.
- Read at p=2 of an address holding 0xA7 → `rd2_n`=0 for 3 cycles (phases 2, 3, 0); `ack` 7 cycles after acceptance with `rdata`=0xA7 in phase 1.
- Sweep p = 0..3 for reads and writes → ack latencies {4,3,6,5} for writes and {5,4,7,6} for reads; `wr2_n` and `rd2_n` are never both low.
- Back-to-back: `req` held high with 3 alternating write/read ops → each op accepted the cycle after its ack; the read returns the preceding write's data.
- `req` pulses while busy → ignored; no extra SRAM access and exactly one `ack` per accepted request.
- `rst` in SLOT_A of a write of 0xFF to a location holding 0x00 → location still 0x00; `ack` never asserts; all outputs at reset values the next cycle; a subsequent request completes normally.
